traffic_lamp_monitor: RTL
=========================

# traffic_lamp_monitor

Safety stage between the traffic-light sequencer and the lamp drivers. It samples the six lamp commands for two approaches and checks every cycle for illegal combinations. Legal patterns pass through registered; short illegal glitches are masked by holding the last legal pattern. An illegal pattern that persists latches a fault and forces both approaches into flashing yellow until an explicit clear.

## Interface
- GLITCH_CYCLES, 4: max consecutive illegal samples tolerated without fault; fault on sample GLITCH_CYCLES+1.
- FLASH_HALF, 500: cycles per half-period of fault flashing (≥1).
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  reset, synchronous, active-high.
- red1_in, yellow1_in, green1_in  input  1 each  approach-1 lamp commands from sequencer.
- red2_in, yellow2_in, green2_in  input  1 each  approach-2 lamp commands from sequencer.
- fault_clr  input  1  request to leave fault mode; only honoured under the conditions in Operation.
- red1, yellow1, green1, red2, yellow2, green2  output  1 each  registered lamp drives.
- fault  output  1  latched fault flag.
- fault_code  output  3  code of the first fault; 0 when no fault.

## Operation
- Illegal-sample classification. Codes are evaluated in priority order; the lowest matching code wins:
  - 1: green1_in & green2_in.
  - 2: more than one of red1_in/yellow1_in/green1_in.
  - 3: more than one of red2_in/yellow2_in/green2_in.
  - 4: approach 1 dark (all three 0).
  - 5: approach 2 dark.
  - 0: sample is legal.
- States: PASS and FLASH.
- PASS, legal sample:
  - outputs <= inputs.
  - glitch counter <= 0.
- PASS, illegal sample, glitch counter < GLITCH_CYCLES:
  - outputs hold their previous value.
  - glitch counter increments.
- PASS, illegal sample, glitch counter == GLITCH_CYCLES:
  - state <= FLASH.
  - fault <= 1.
  - fault_code <= code of this sample.
  - flash phase <= 1, flash counter <= 0.
- FLASH outputs:
  - red1 = red2 = green1 = green2 = 0.
  - yellow1 = yellow2 = flash phase.
  - flash counter counts 0..FLASH_HALF-1; at FLASH_HALF-1 it wraps to 0 and the phase toggles.
- FLASH, new illegal samples: ignored; fault_code keeps the first code.
- FLASH exit: fault_clr=1 with a legal sample on the same edge moves to PASS. On that edge:
  - outputs <= inputs.
  - fault <= 0, fault_code <= 0.
  - glitch counter <= 0.
- FLASH, fault_clr with an illegal sample: ignored; stays in FLASH.
- PASS, fault_clr: ignored.
- Counter widths:
  - glitch counter is clog2(GLITCH_CYCLES+1) bits, minimum 1.
  - flash counter is clog2(FLASH_HALF) bits, minimum 1.
  - neither counter wraps outside its defined range.
- GLITCH_CYCLES=0: the first illegal sample faults immediately.

## Timing
- Reset values, applied on the edge where reset is high, and also when reset is asserted mid-operation:
  - red1=red2=1; yellow1, green1, yellow2, green2 = 0 (all-red).
  - fault=0, fault_code=0.
  - state PASS; glitch counter, flash counter and flash phase = 0.
- Pass-through latency: 1 cycle. An input sampled at edge k appears on the outputs after edge k.
- Fault latency: when samples at edges k..k+GLITCH_CYCLES are all illegal, fault=1 and flashing yellow are visible after edge k+GLITCH_CYCLES.
- During the glitch window, outputs show the last legal pattern.
- Flash timing: the first yellow-on window is exactly FLASH_HALF cycles, followed by FLASH_HALF cycles off, repeating.
- Clear latency: fault_clr and a legal sample at edge m give fault=0 and pass-through outputs after edge m.
- Simultaneous legal sample and fault_clr while in PASS: normal pass-through; fault_clr has no effect.

## Test plan
Bench parameters: GLITCH_CYCLES=4, FLASH_HALF=8.
- Reset, then drive red1_in=1, green2_in=1 -> one cycle later red1=1, green2=1, others 0; fault=0, fault_code=0.
- After the legal pattern above, drive green1_in=green2_in=1 for 4 cycles, then return to legal -> outputs hold red1=1, green2=1 throughout; fault stays 0.
- Drive green1_in=green2_in=1 for 5 cycles -> fault=1, fault_code=1 after the 5th edge. Then yellow1=yellow2=1 for 8 cycles, 0 for 8 cycles, 1 again; red and green outputs 0.
- Drive approach 2 all-zero for 5 cycles -> fault_code=5. Separately drive green1, yellow2 and green2 together for 5 cycles -> fault_code=1 (priority over 3).
- While in FLASH: fault_clr=1 with illegal inputs -> stays flashing. fault_clr=1 with red1_in, green2_in -> next cycle fault=0, fault_code=0, outputs red1=1, green2=1.
- Assert reset mid-FLASH -> after the edge red1=red2=1, all others 0, fault=0; the next legal input passes through one cycle later.

Source files
------------

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor
// Safety stage between the traffic-light sequencer and the lamp drivers.
// Every cycle the six lamp commands are classified. Legal patterns are passed
// through one register stage; short runs of illegal samples are masked by
// holding the last legal pattern. A run longer than GLITCH_CYCLES latches a
// fault and both approaches flash yellow until fault_clr is seen together
// with a legal sample.

module traffic_lamp_monitor #(
  parameter int GLITCH_CYCLES = 4,
  parameter int FLASH_HALF    = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       red1_in,
  input  logic       yellow1_in,
  input  logic       green1_in,
  input  logic       red2_in,
  input  logic       yellow2_in,
  input  logic       green2_in,
  input  logic       fault_clr,
  output logic       red1,
  output logic       yellow1,
  output logic       green1,
  output logic       red2,
  output logic       yellow2,
  output logic       green2,
  output logic       fault,
  output logic [2:0] fault_code
);

  // Counter widths; both are at least one bit so the degenerate parameter
  // values (GLITCH_CYCLES=0, FLASH_HALF=1) still give legal vectors.
  localparam int GW = ($clog2(GLITCH_CYCLES + 1) > 0) ? $clog2(GLITCH_CYCLES + 1) : 1;
  localparam int FW = ($clog2(FLASH_HALF) > 0) ? $clog2(FLASH_HALF) : 1;

  localparam logic [GW-1:0] GLITCH_MAX = GW'(GLITCH_CYCLES);
  localparam logic [FW-1:0] FLASH_MAX  = FW'(FLASH_HALF - 1);

  // Lamp vector layout: {red1, yellow1, green1, red2, yellow2, green2}
  localparam logic [5:0] LAMPS_ALL_RED = 6'b100_100;

  typedef enum logic [0:0] {
    ST_PASS  = 1'b0,
    ST_FLASH = 1'b1
  } state_t;

  // True when two or more of the three lamps of one approach are lit.
  function automatic logic more_than_one(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

  // Illegal-pattern classification; the lowest matching code wins, 0 = legal.
  function automatic logic [2:0] classify(input logic [5:0] l);
    logic [2:0] code;
    code = 3'd0;
    if (l[3] & l[0]) begin
      code = 3'd1;                       // both greens
    end else if (more_than_one(l[5:3])) begin
      code = 3'd2;                       // approach 1 multi-lamp
    end else if (more_than_one(l[2:0])) begin
      code = 3'd3;                       // approach 2 multi-lamp
    end else if (l[5:3] == 3'b000) begin
      code = 3'd4;                       // approach 1 dark
    end else if (l[2:0] == 3'b000) begin
      code = 3'd5;                       // approach 2 dark
    end else begin
      code = 3'd0;
    end
    return code;
  endfunction

  // Fault-mode lamp pattern: only the two yellows, driven by the flash phase.
  function automatic logic [5:0] flash_lamps(input logic phase);
    return {1'b0, phase, 1'b0, 1'b0, phase, 1'b0};
  endfunction

  logic [5:0]    lamps_in_s;
  logic [2:0]    code_s;

  state_t        state_r,  state_next_s;
  logic [5:0]    lamps_r,  lamps_next_s;
  logic          fault_r,  fault_next_s;
  logic [2:0]    code_r,   code_next_s;
  logic [GW-1:0] glitch_r, glitch_next_s;
  logic [FW-1:0] flash_r,  flash_next_s;
  logic          phase_r,  phase_next_s;

  assign lamps_in_s = {red1_in, yellow1_in, green1_in, red2_in, yellow2_in, green2_in};
  assign code_s     = classify(lamps_in_s);

  // Next-state, next-lamp and counter logic for the PASS/FLASH machine.
  always_comb begin
    state_next_s  = state_r;
    lamps_next_s  = lamps_r;
    fault_next_s  = fault_r;
    code_next_s   = code_r;
    glitch_next_s = glitch_r;
    flash_next_s  = flash_r;
    phase_next_s  = phase_r;

    case (state_r)
      ST_PASS: begin
        if (code_s == 3'd0) begin
          // Legal: pass through and restart the glitch window.
          lamps_next_s  = lamps_in_s;
          glitch_next_s = {GW{1'b0}};
        end else if (glitch_r < GLITCH_MAX) begin
          // Tolerated glitch: lamps hold the last legal pattern.
          glitch_next_s = glitch_r + {{(GW-1){1'b0}}, 1'b1};
        end else begin
          // Glitch window exhausted: latch the fault and start flashing on.
          state_next_s  = ST_FLASH;
          fault_next_s  = 1'b1;
          code_next_s   = code_s;
          phase_next_s  = 1'b1;
          flash_next_s  = {FW{1'b0}};
          glitch_next_s = {GW{1'b0}};
          lamps_next_s  = flash_lamps(1'b1);
        end
      end

      ST_FLASH: begin
        if (fault_clr && (code_s == 3'd0)) begin
          // Clear accepted only together with a legal sample.
          state_next_s  = ST_PASS;
          fault_next_s  = 1'b0;
          code_next_s   = 3'd0;
          glitch_next_s = {GW{1'b0}};
          flash_next_s  = {FW{1'b0}};
          phase_next_s  = 1'b0;
          lamps_next_s  = lamps_in_s;
        end else if (flash_r == FLASH_MAX) begin
          // End of a half-period: wrap and toggle the yellow phase.
          flash_next_s = {FW{1'b0}};
          phase_next_s = ~phase_r;
          lamps_next_s = flash_lamps(~phase_r);
        end else begin
          flash_next_s = flash_r + {{(FW-1){1'b0}}, 1'b1};
          lamps_next_s = flash_lamps(phase_r);
        end
      end

      default: begin
        // Unreachable encoding: fall back to the safe all-red pass state.
        state_next_s  = ST_PASS;
        lamps_next_s  = LAMPS_ALL_RED;
        fault_next_s  = 1'b0;
        code_next_s   = 3'd0;
        glitch_next_s = {GW{1'b0}};
        flash_next_s  = {FW{1'b0}};
        phase_next_s  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; synchronous reset forces all-red PASS.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_PASS;
      lamps_r  <= LAMPS_ALL_RED;
      fault_r  <= 1'b0;
      code_r   <= 3'd0;
      glitch_r <= {GW{1'b0}};
      flash_r  <= {FW{1'b0}};
      phase_r  <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      lamps_r  <= lamps_next_s;
      fault_r  <= fault_next_s;
      code_r   <= code_next_s;
      glitch_r <= glitch_next_s;
      flash_r  <= flash_next_s;
      phase_r  <= phase_next_s;
    end
  end

  assign {red1, yellow1, green1, red2, yellow2, green2} = lamps_r;
  assign fault      = fault_r;
  assign fault_code = code_r;

endmodule
